uart_line_loader: RTL and testbench
===================================

// Module: uart_line_loader
// PURPOSE
// Parametrised UART line-packet loader: parses a framed byte stream from uart_receiver, streams pixels of one video line
// into an external line RAM via a write port, validates row, XOR checksum and end word, and paces the host with
// acknowledge bytes to uart_transmiter. Sits between the UART pair and the VGA line buffer.
// PARAMETERS
// PIX_BITS       24     bits per pixel; multiple of 8 (8/16/24/32); bytes per pixel BPP = PIX_BITS/8
// WIDTH          640    pixels per line; payload bytes N = WIDTH*BPP
// HEIGHT         480    valid rows 0..HEIGHT-1
// ROW_BITS       9      width of line_row
// SOF_CODE       8'h55  start-of-frame byte
// END_WORD       8'hDD  end-of-packet byte
// ACK_CODE       8'hAA  intermediate acknowledge
// OK_CODE        8'hBC  line accepted
// NAK_CODE       8'h11  line rejected
// ACK_EVERY      16     payload bytes between intermediate ACKs (>=1)
// PAUSE_CYCLES   16     clk cycles between trigger and tx_start of any response
// TIMEOUT_CYCLES 2_000_000  max idle clk cycles between bytes inside a packet
// PORTS
// clk        in   1            system clock
// rst        in   1            asynchronous reset, active-high
// rx_data    in   8            received byte
// rx_valid   in   1            one-cycle strobe, rx_data valid
// tx_data    out  8            response byte, stable from tx_start until tx_busy falls
// tx_start   out  1            one-cycle strobe to transmitter
// tx_busy    in   1            transmitter busy
// wr_en      out  1            line RAM write strobe
// wr_addr    out  $clog2(WIDTH) pixel index
// wr_data    out  PIX_BITS     pixel, first received byte = LSB
// line_row   out  ROW_BITS     row of current/last packet
// line_done  out  1            one-cycle pulse: line in RAM is complete and valid
// err        out  1            one-cycle pulse on rejection
// err_code   out  3            1=bad row 2=checksum 3=bad end word 4=timeout 5=overrun; held until next err
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; all outputs 0; counters, checksum, pixel shift reg cleared.
// - Packet: SOF, ROW_HI, ROW_LO, N payload bytes, CSUM, END. row={ROW_HI,ROW_LO}[ROW_BITS-1:0].
//   CSUM must equal XOR of ROW_HI, ROW_LO and all payload bytes.
// - States: IDLE, ROW_H, ROW_L, PAYLOAD, CSUM, EOP, PAUSE, SEND, WAIT; a return-state reg selects the state after WAIT.
// - IDLE: rx_valid with rx_data==SOF_CODE -> ROW_H; any other byte is ignored silently.
// - ROW_L: row>=HEIGHT -> respond NAK, err code 1, return IDLE; else line_row<=row, respond ACK, return PAYLOAD.
// - PAYLOAD: bytes shift into pixel reg; on BPP-th byte wr_en=1 for one cycle, in the cycle after that byte's rx_valid,
//   with wr_addr=pixel index; index increments 0..WIDTH-1, no wrap.
//   After each ACK_EVERY-th payload byte (byte count multiple of ACK_EVERY, and not the N-th byte):
//   respond ACK, return PAYLOAD. After the N-th byte -> CSUM with no ACK.
// - CSUM: latch compare result -> EOP. EOP: rx_data!=END_WORD -> NAK code 3; checksum bad -> NAK code 2
//   (code 3 wins if both); else OK_CODE, line_done pulses in the cycle tx_start is issued. Return IDLE.
// - Response path: PAUSE counts PAUSE_CYCLES, then tx_start=1 one cycle (only if tx_busy=0, else hold in PAUSE)
//   -> SEND. SEND waits for tx_busy=1 -> WAIT. WAIT waits for tx_busy=0 -> return state.
// - Overrun: rx_valid in PAUSE/SEND/WAIT, other than for a final OK/NAK response, drops the byte and sets sticky flag.
//   The next final response of that packet is NAK code 5, regardless of checksum and end word.
// - Timeout: in ROW_H..EOP an idle counter resets on each rx_valid. When it reaches TIMEOUT_CYCLES, respond NAK
//   code 4 and return IDLE. The counter is frozen in the response states.
// - err pulses together with tx_start of any NAK. No line_done on any NAK; RAM contents already written are
//   considered invalid.
// - rx_valid coincident with a state transition is consumed by the current state only.
// - rst asserted mid-packet: immediate IDLE; a transmission in flight is abandoned; no pulses.
// TESTING
// - Good packet, PIX_BITS=24, WIDTH=4, ACK_EVERY=4, row 0x012, correct CSUM, END 0xDD -> responses AA,AA,AA then BC.
//   Same packet: 4 writes addr 0..3 with first pixel = {b2,b1,b0}; line_done=1, line_row=18.
// - Row 0x01E0 (=480) -> NAK 0x11, err code 1, no wr_en, FSM back in IDLE.
// - Corrupt one payload byte -> final NAK, err code 2; with bad END too -> err code 3.
// - Stop sending after 5 payload bytes -> after TIMEOUT_CYCLES, NAK with code 4; next valid packet accepted.
// - Host sends a byte during an ACK pause -> byte dropped; final NAK code 5.
// - Garbage bytes 0x00,0xFF before SOF are ignored. rst pulse mid-payload -> outputs 0; fresh packet completes with BC.

Source files
------------

// File: rtl/uart_line_loader.sv
// uart_line_loader: parses framed UART line packets, writes pixels into an external
// line RAM and paces the host with ACK / OK / NAK response bytes.
module uart_line_loader #(
    parameter int unsigned PIX_BITS       = 24,
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned ROW_BITS       = 9,
    parameter logic [7:0]  SOF_CODE       = 8'h55,
    parameter logic [7:0]  END_WORD       = 8'hDD,
    parameter logic [7:0]  ACK_CODE       = 8'hAA,
    parameter logic [7:0]  OK_CODE        = 8'hBC,
    parameter logic [7:0]  NAK_CODE       = 8'h11,
    parameter int unsigned ACK_EVERY      = 16,
    parameter int unsigned PAUSE_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     wr_en,
    output logic [$clog2(WIDTH)-1:0] wr_addr,
    output logic [PIX_BITS-1:0]      wr_data,
    output logic [ROW_BITS-1:0]      line_row,
    output logic                     line_done,
    output logic                     err,
    output logic [2:0]               err_code
);
    localparam int unsigned BPP  = PIX_BITS / 8;
    localparam int unsigned NB   = WIDTH * BPP;
    localparam int unsigned AW   = $clog2(WIDTH);
    localparam int unsigned BW   = $clog2(NB + 1);
    localparam int unsigned KW   = $clog2(ACK_EVERY + 1);
    localparam int unsigned PW   = $clog2(PAUSE_CYCLES + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW   = 3;
    localparam int unsigned PEND = (PAUSE_CYCLES > 0) ? PAUSE_CYCLES - 1 : 0;
    localparam int unsigned TEND = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_ROW     = 3'd1;
    localparam logic [2:0] E_CSUM    = 3'd2;
    localparam logic [2:0] E_END     = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;
    localparam logic [2:0] E_OVERRUN = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_ROW_H, S_ROW_L, S_PAYLOAD, S_CSUM, S_EOP, S_PAUSE, S_SEND, S_WAIT
    } state_t;

    state_t              state_q, state_d, ret_q, ret_d;
    logic [7:0]          resp_q, resp_d;
    logic [2:0]          code_q, code_d;
    logic                final_q, final_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic [7:0]          row_hi_q, row_hi_d;
    logic [7:0]          xor_q, xor_d;
    logic                csum_ok_q, csum_ok_d;
    logic                ovr_q, ovr_d;
    logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [KW-1:0]       ack_cnt_q, ack_cnt_d;
    logic [SW-1:0]       sub_q, sub_d;
    logic [AW-1:0]       pix_idx_q, pix_idx_d;
    logic [PIX_BITS-1:0] pix_q, pix_d;

    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [PIX_BITS-1:0] wr_data_q, wr_data_d;
    logic [ROW_BITS-1:0] line_row_q, line_row_d;
    logic                line_done_q, line_done_d;
    logic                err_q, err_d;
    logic [2:0]          err_code_q, err_code_d;

    logic [PIX_BITS-1:0] pix_next_c;
    logic [ROW_BITS-1:0] row_c;
    logic                resp_go;
    logic [7:0]          resp_byte;
    logic [2:0]          resp_code;
    logic                resp_final;
    state_t              resp_ret;

    // First received byte of a pixel ends up in the LSBs.
    assign pix_next_c = (pix_q >> 8) | (PIX_BITS'(rx_data) << (PIX_BITS - 8));
    assign row_c      = ROW_BITS'({row_hi_q, rx_data});

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        resp_d      = resp_q;
        code_d      = code_q;
        final_d     = final_q;
        pcnt_d      = pcnt_q;
        idle_d      = idle_q;
        row_hi_d    = row_hi_q;
        xor_d       = xor_q;
        csum_ok_d   = csum_ok_q;
        ovr_d       = ovr_q;
        byte_cnt_d  = byte_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        sub_d       = sub_q;
        pix_idx_d   = pix_idx_q;
        pix_d       = pix_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        line_row_d  = line_row_q;
        line_done_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        resp_go     = 1'b0;
        resp_byte   = NAK_CODE;
        resp_code   = E_NONE;
        resp_final  = 1'b1;
        resp_ret    = S_IDLE;

        // Inter-byte idle watchdog, only while a packet is being parsed.
        if (state_q inside {S_ROW_H, S_ROW_L, S_PAYLOAD, S_CSUM, S_EOP}) begin
            if (rx_valid) begin
                idle_d = '0;
            end else if (idle_q == TW'(TEND)) begin
                resp_go   = 1'b1;
                resp_code = E_TIMEOUT;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end

        // Host bytes arriving while an intermediate ACK is pending are dropped.
        if (state_q inside {S_PAUSE, S_SEND, S_WAIT}) begin
            if (rx_valid && !final_q) ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (rx_valid && rx_data == SOF_CODE) begin
                    state_d    = S_ROW_H;
                    ovr_d      = 1'b0;
                    xor_d      = '0;
                    byte_cnt_d = '0;
                    ack_cnt_d  = '0;
                    sub_d      = '0;
                    pix_idx_d  = '0;
                    pix_d      = '0;
                end
            end
            S_ROW_H: begin
                if (rx_valid) begin
                    row_hi_d = rx_data;
                    xor_d    = xor_q ^ rx_data;
                    state_d  = S_ROW_L;
                end
            end
            S_ROW_L: begin
                if (rx_valid) begin
                    xor_d   = xor_q ^ rx_data;
                    resp_go = 1'b1;
                    if (32'(row_c) >= HEIGHT) begin
                        resp_code = E_ROW;
                    end else begin
                        line_row_d = row_c;
                        resp_byte  = ACK_CODE;
                        resp_final = 1'b0;
                        resp_ret   = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    xor_d      = xor_q ^ rx_data;
                    pix_d      = pix_next_c;
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (sub_q == SW'(BPP - 1)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_idx_q;
                        wr_data_d = pix_next_c;
                        sub_d     = '0;
                        if (pix_idx_q != AW'(WIDTH - 1)) pix_idx_d = pix_idx_q + AW'(1);
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                    if (byte_cnt_q == BW'(NB - 1)) begin
                        state_d = S_CSUM;
                    end else if (ack_cnt_q == KW'(ACK_EVERY - 1)) begin
                        ack_cnt_d  = '0;
                        resp_go    = 1'b1;
                        resp_byte  = ACK_CODE;
                        resp_final = 1'b0;
                        resp_ret   = S_PAYLOAD;
                    end else begin
                        ack_cnt_d = ack_cnt_q + KW'(1);
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    csum_ok_d = (rx_data == xor_q);
                    state_d   = S_EOP;
                end
            end
            S_EOP: begin
                if (rx_valid) begin
                    resp_go = 1'b1;
                    if (ovr_q)                      resp_code = E_OVERRUN;
                    else if (rx_data != END_WORD)   resp_code = E_END;
                    else if (!csum_ok_q)            resp_code = E_CSUM;
                    else                            resp_byte = OK_CODE;
                end
            end
            S_PAUSE: begin
                if (pcnt_q == PW'(PEND)) begin
                    if (!tx_busy) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = resp_q;
                        state_d    = S_SEND;
                        if (code_q != E_NONE) begin
                            err_d      = 1'b1;
                            err_code_d = code_q;
                        end else if (final_q) begin
                            line_done_d = 1'b1;
                        end
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_SEND: begin
                if (tx_busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) state_d = ret_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Every response funnels through the same pause/send/wait path.
        if (resp_go) begin
            state_d = S_PAUSE;
            ret_d   = resp_ret;
            resp_d  = resp_byte;
            code_d  = resp_code;
            final_d = resp_final;
            pcnt_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            resp_q      <= '0;
            code_q      <= '0;
            final_q     <= 1'b0;
            pcnt_q      <= '0;
            idle_q      <= '0;
            row_hi_q    <= '0;
            xor_q       <= '0;
            csum_ok_q   <= 1'b0;
            ovr_q       <= 1'b0;
            byte_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            sub_q       <= '0;
            pix_idx_q   <= '0;
            pix_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            line_row_q  <= '0;
            line_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            resp_q      <= resp_d;
            code_q      <= code_d;
            final_q     <= final_d;
            pcnt_q      <= pcnt_d;
            idle_q      <= idle_d;
            row_hi_q    <= row_hi_d;
            xor_q       <= xor_d;
            csum_ok_q   <= csum_ok_d;
            ovr_q       <= ovr_d;
            byte_cnt_q  <= byte_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            sub_q       <= sub_d;
            pix_idx_q   <= pix_idx_d;
            pix_q       <= pix_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            line_row_q  <= line_row_d;
            line_done_q <= line_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign line_row  = line_row_q;
    assign line_done = line_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_line_loader.sv
// Bench for uart_line_loader: host driver, transmitter model and a packet-level
// reference that predicts responses, error codes and RAM writes from the packet bytes.
module tb_uart_line_loader;
    localparam int unsigned PIX_BITS       = 24;
    localparam int unsigned WIDTH          = 4;
    localparam int unsigned HEIGHT         = 480;
    localparam int unsigned ROW_BITS       = 9;
    localparam int unsigned ACK_EVERY      = 4;
    localparam int unsigned PAUSE_CYCLES   = 16;
    localparam int unsigned TIMEOUT_CYCLES = 300;
    localparam int unsigned BPP            = PIX_BITS / 8;
    localparam int unsigned NB             = WIDTH * BPP;
    localparam int unsigned AW             = $clog2(WIDTH);
    localparam logic [7:0]  SOF  = 8'h55;
    localparam logic [7:0]  ENDW = 8'hDD;
    localparam logic [7:0]  ACK  = 8'hAA;
    localparam logic [7:0]  OK   = 8'hBC;
    localparam logic [7:0]  NAK  = 8'h11;

    typedef logic [7:0] pay_t [NB];
    typedef struct {
        logic [7:0]  b;
        logic        e;
        logic [2:0]  c;
        logic        d;
        int unsigned t;
    } resp_t;

    logic                clk      = 1'b0;
    logic                rst      = 1'b0;
    logic [7:0]          rx_data  = 8'h00;
    logic                rx_valid = 1'b0;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [PIX_BITS-1:0] wr_data;
    logic [ROW_BITS-1:0] line_row;
    logic                line_done;
    logic                err;
    logic [2:0]          err_code;

    int unsigned cyc    = 0;
    int unsigned t_sent = 0;
    int unsigned last_t = 0;
    int          tests  = 0;
    int          fails  = 0;
    int          stray  = 0;
    int          rd     = 0;
    int          bleft  = 0;
    resp_t               rq[$];
    logic [AW-1:0]       wa_q[$];
    logic [PIX_BITS-1:0] wd_q[$];

    uart_line_loader #(
        .PIX_BITS(PIX_BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_BITS(ROW_BITS),
        .ACK_EVERY(ACK_EVERY), .PAUSE_CYCLES(PAUSE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_row(line_row), .line_done(line_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for a few cycles after each tx_start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            bleft   <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bleft   <= 4 + int'($urandom_range(0, 3));
        end else if (bleft > 1) begin
            bleft <= bleft - 1;
        end else begin
            tx_busy <= 1'b0;
            bleft   <= 0;
        end
    end

    // Output monitor: records responses and RAM writes.
    always @(negedge clk) begin
        if (tx_start) rq.push_back('{b: tx_data, e: err, c: err_code, d: line_done, t: cyc});
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if ((err || line_done) && !tx_start) stray <= stray + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        t_sent   = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp(input string tag, input logic [7:0] eb, input logic [2:0] ec,
                             input logic ed, input int bound, input logic chk_lat);
        int    n;
        logic  got;
        resp_t r;
        n = 0;
        while (rq.size() <= rd && n < bound) begin
            @(negedge clk);
            n++;
        end
        got = (rq.size() > rd);
        chk({tag, "_seen"}, 32'(got), 32'(1));
        if (got) begin
            r = rq[rd];
            rd++;
            last_t = r.t;
            chk({tag, "_byte"}, 32'(r.b), 32'(eb));
            chk({tag, "_err"}, 32'(r.e), 32'(ec != 3'd0));
            if (ec != 3'd0) chk({tag, "_code"}, 32'(r.c), 32'(ec));
            chk({tag, "_done"}, 32'(r.d), 32'(ed));
            if (chk_lat)
                chk({tag, "_pause"}, 32'((r.t - t_sent >= PAUSE_CYCLES) && (r.t - t_sent <= PAUSE_CYCLES + 2)), 32'(1));
            repeat (2) @(negedge clk);
            n = 0;
            while (tx_busy && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (2) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [15:0] row, input pay_t pl);
        logic [7:0] x;
        x = row[15:8] ^ row[7:0];
        for (int i = 0; i < int'(NB); i++) x = x ^ pl[i];
        return x;
    endfunction

    // Sends one packet and checks every response and write against the packet rules.
    task automatic run_packet(input string tag, input logic [15:0] row, input pay_t pl,
                              input logic [7:0] cs, input logic [7:0] eb, input int ovr_at);
        logic [ROW_BITS-1:0] r9;
        logic [2:0]          fcode;
        logic [PIX_BITS-1:0] px;
        int                  wbase;
        r9    = ROW_BITS'(row);
        wbase = wa_q.size();
        send_byte(SOF);
        send_byte(row[15:8]);
        send_byte(row[7:0]);
        if (32'(r9) >= HEIGHT) begin
            wait_resp({tag, "_row"}, NAK, 3'd1, 1'b0, 200, 1'b1);
            chk({tag, "_nowr"}, 32'(wa_q.size() - wbase), 32'(0));
            return;
        end
        wait_resp({tag, "_ack0"}, ACK, 3'd0, 1'b0, 200, 1'b1);
        for (int k = 1; k <= int'(NB); k++) begin
            send_byte(pl[k-1]);
            if (k % int'(ACK_EVERY) == 0 && k != int'(NB)) begin
                if (k == ovr_at) begin
                    repeat (3) @(negedge clk);
                    send_byte(8'h5A);
                end
                wait_resp($sformatf("%s_ack%0d", tag, k), ACK, 3'd0, 1'b0, 200, 1'(k != ovr_at));
            end
        end
        send_byte(cs);
        send_byte(eb);
        if (ovr_at != 0)            fcode = 3'd5;
        else if (eb != ENDW)        fcode = 3'd3;
        else if (cs != xsum(row, pl)) fcode = 3'd2;
        else                        fcode = 3'd0;
        wait_resp({tag, "_final"}, (fcode == 3'd0) ? OK : NAK, fcode, 1'(fcode == 3'd0), 200, 1'b1);
        chk({tag, "_nwr"}, 32'(wa_q.size() - wbase), 32'(WIDTH));
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (wbase + i < wa_q.size()) begin
                for (int b = 0; b < int'(BPP); b++) px[8*b +: 8] = pl[int'(BPP)*i + b];
                chk($sformatf("%s_wa%0d", tag, i), 32'(wa_q[wbase+i]), 32'(i));
                chk($sformatf("%s_wd%0d", tag, i), 32'(wd_q[wbase+i]), 32'(px));
            end
        end
        if (fcode == 3'd0) chk({tag, "_row_out"}, 32'(line_row), 32'(r9));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'(0));
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(0));
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
        chk({tag, "_wr_data"}, 32'(wr_data), 32'(0));
        chk({tag, "_line_row"}, 32'(line_row), 32'(0));
        chk({tag, "_line_done"}, 32'(line_done), 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(0));
        chk({tag, "_err_code"}, 32'(err_code), 32'(0));
    endtask

    initial begin
        pay_t        pl;
        logic [15:0] row;
        logic [7:0]  cs;
        logic [7:0]  eb;
        int          mode;
        int          ov;
        int unsigned t0;

        // Reset values.
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Garbage before SOF, then a good packet on row 0x012.
        send_byte(8'h00);
        send_byte(8'hFF);
        foreach (pl[i]) pl[i] = 8'($urandom);
        run_packet("good", 16'h0012, pl, xsum(16'h0012, pl), ENDW, 0);
        chk("good_row18", 32'(line_row), 32'(18));

        // Row out of range.
        run_packet("badrow", 16'h01E0, pl, xsum(16'h01E0, pl), ENDW, 0);

        // Corrupted payload, then corrupted payload plus bad end word.
        foreach (pl[i]) pl[i] = 8'($urandom);
        cs = xsum(16'h0033, pl);
        pl[5] = pl[5] ^ 8'h40;
        run_packet("csum", 16'h0033, pl, cs, ENDW, 0);
        run_packet("csum_end", 16'h0033, pl, cs, 8'hDC, 0);

        // Host stalls after five payload bytes.
        send_byte(SOF);
        send_byte(8'h00);
        send_byte(8'h05);
        wait_resp("to_ack0", ACK, 3'd0, 1'b0, 200, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            send_byte(8'(k * 17));
            if (k == int'(ACK_EVERY)) wait_resp("to_ack4", ACK, 3'd0, 1'b0, 200, 1'b1);
        end
        t0 = t_sent;
        wait_resp("to_nak", NAK, 3'd4, 1'b0, int'(TIMEOUT_CYCLES + PAUSE_CYCLES) + 100, 1'b0);
        chk("to_delay", 32'((last_t - t0 >= TIMEOUT_CYCLES + PAUSE_CYCLES) &&
                            (last_t - t0 <= TIMEOUT_CYCLES + PAUSE_CYCLES + 3)), 32'(1));
        foreach (pl[i]) pl[i] = 8'($urandom);
        run_packet("after_to", 16'h0100, pl, xsum(16'h0100, pl), ENDW, 0);

        // Extra host byte during an intermediate ACK pause.
        run_packet("ovr", 16'h0042, pl, xsum(16'h0042, pl), ENDW, int'(ACK_EVERY));

        // Reset in the middle of the payload.
        send_byte(SOF);
        send_byte(8'h00);
        send_byte(8'h07);
        wait_resp("mid_ack0", ACK, 3'd0, 1'b0, 200, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            send_byte(8'(k + 3));
            if (k == int'(ACK_EVERY)) wait_resp("mid_ack4", ACK, 3'd0, 1'b0, 200, 1'b1);
        end
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        rd = rq.size();
        repeat (2) @(negedge clk);
        foreach (pl[i]) pl[i] = 8'($urandom);
        run_packet("after_rst", 16'h01DF, pl, xsum(16'h01DF, pl), ENDW, 0);

        // Randomised packets with random faults.
        for (int p = 0; p < 8; p++) begin
            row = 16'($urandom_range(0, HEIGHT - 1));
            foreach (pl[i]) pl[i] = 8'($urandom);
            mode = int'($urandom_range(0, 4));
            cs = xsum(row, pl);
            eb = ENDW;
            ov = 0;
            if (mode == 1 || mode == 3) cs = cs ^ 8'($urandom_range(1, 255));
            if (mode == 2 || mode == 3) eb = ENDW ^ 8'($urandom_range(1, 255));
            if (mode == 4) ov = int'(ACK_EVERY) * int'($urandom_range(1, (NB - 1) / ACK_EVERY));
            run_packet($sformatf("rnd%0d", p), row, pl, cs, eb, ov);
        end

        chk("stray_pulses", 32'(stray), 32'(0));
        chk("unread_resp", 32'(rq.size() - rd), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
